// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: redirect controls, memory handshake and PC outputs.
// master = the sequencer, slave = control unit / memory side driving it.
interface pc_sequencer_if;
  logic        stall;
  logic        br_take;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        redirect_pend;
  logic        addr_err;

  modport master (
    input  stall, br_take, br_offset, jump, jump_index, jr, jr_target, exc, imem_ready,
    output pc, imem_req, redirect_pend, addr_err
  );

  modport slave (
    output stall, br_take, br_offset, jump, jump_index, jr, jr_target, exc, imem_ready,
    input  pc, imem_req, redirect_pend, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner: next-PC selection, redirect latching and fetch throttling.
// Optional ALIGN_CHECK_EN: a misaligned jr traps to EXC_VECTOR and pulses addr_err.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.master bus
);
  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
  logic        imem_req_q, imem_req_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc4, br_tgt, jmp_tgt, jr_tgt, redir_tgt, adv_tgt;
  logic        redir, misalign, trap, advance;

  assign pc4     = pc_q + 32'd4;
  assign br_tgt  = pc4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
  assign jmp_tgt = {pc4[31:28], bus.jump_index, 2'b00};
  assign jr_tgt  = {bus.jr_target[31:2], 2'b00};
  assign redir   = bus.jr | bus.jump | bus.br_take;

`ifdef ALIGN_CHECK_EN
  assign misalign = bus.jr & (bus.jr_target[1:0] != 2'b00);
`else
  logic unused_jr_lsb;
  assign unused_jr_lsb = ^bus.jr_target[1:0];
  assign misalign      = 1'b0;
`endif

  assign trap = bus.exc | misalign;

  always_comb begin
    if (bus.jr)        redir_tgt = jr_tgt;
    else if (bus.jump) redir_tgt = jmp_tgt;
    else               redir_tgt = br_tgt;
  end

  // A fresh redirect beats a latched one; otherwise fall through to sequential.
  assign adv_tgt = redir ? redir_tgt : (pend_q ? pend_tgt_q : pc4);

  assign advance = ((state_q == StFetch) && bus.imem_ready && !bus.stall) ||
                   ((state_q == StHold) && !bus.stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (trap) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StBoot:  state_d = StFetch;
        StFetch: if (bus.imem_ready && bus.stall) state_d = StHold;
        StHold:  if (!bus.stall) state_d = StFetch;
        default: state_d = StBoot;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    imem_req_d = (state_d == StFetch);
    addr_err_d = misalign;
    if (trap) begin
      pc_d   = EXC_VECTOR;
      pend_d = 1'b0;
    end else if (advance) begin
      pc_d   = adv_tgt;
      pend_d = 1'b0;
    end else if (redir) begin
      pend_d     = 1'b1;
      pend_tgt_d = redir_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0;
      pend_q     <= 1'b0;
      imem_req_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
      imem_req_q <= imem_req_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.imem_req      = imem_req_q;
  assign bus.redirect_pend = pend_q;
  assign bus.addr_err      = addr_err_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the fetch program counter and sequences instruction-memory requests for the CPU front end. It selects the next PC from four sources: sequential (+4), PC-relative branch (sign-extended offset shifted left 2), jump (26-bit index shifted left 2), and register jump. It also handles exception redirect. It throttles fetch on memory back-pressure and pipeline stall. Sits between the control unit / branch comparator and the instruction memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, exception entry address

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  downstream cannot accept a fetched instruction
br_take  input  1  take PC-relative branch
br_offset  input  16  signed word offset
jump  input  1  take absolute jump
jump_index  input  26  jump word index
jr  input  1  take register jump
jr_target  input  32  register jump byte address
exc  input  1  exception redirect request
imem_ready  input  1  instruction memory completes the current request this cycle
pc  output  32  address currently being fetched (registered)
imem_req  output  1  fetch request (registered)
redirect_pend  output  1  a redirect is latched and not yet applied (registered)
addr_err  output  1  one-cycle pulse on misaligned jr (only with ALIGN_CHECK_EN)

Behaviour:
- Reset values: pc=RESET_PC, imem_req=0, redirect_pend=0, addr_err=0, state=BOOT. Reset mid-fetch or mid-hold discards all pending state.
- States are BOOT, FETCH and HOLD.
- BOOT: next cycle goes to FETCH and sets imem_req=1.
- FETCH: imem_req=1.
  - accept = imem_ready.
  - accept & !stall ("advance"): pc <= next_pc; stay in FETCH.
  - accept & stall: go to HOLD, imem_req <= 0, pc unchanged.
  - !accept: pc unchanged.
- HOLD: imem_req=0. When stall=0, advance (pc <= next_pc), imem_req <= 1, go to FETCH. imem_ready is ignored in HOLD.
- Target arithmetic (mod 2^32, relative to the current pc register):
  - pc4 = pc+4
  - branch target = pc4 + ({{14{br_offset[15]}},br_offset,2'b00})
  - jump target = {pc4[31:28], jump_index, 2'b00}
  - jr target = {jr_target[31:2], 2'b00}
- next_pc priority: exc > jr > jump > br_take > pending redirect > pc4.
- Pending redirect:
  - A jr, jump or br_take asserted in a cycle without advance latches its target into a pending register and sets redirect_pend=1.
  - A later redirect overwrites the pending one. Priority applies when several are asserted in the same cycle.
  - At the next advance, the pending target is used (unless a new redirect is present that cycle) and redirect_pend clears.
- Exception:
  - exc in any state other than BOOT forces pc <= EXC_VECTOR on that edge, regardless of accept or stall.
  - It clears pending and goes to FETCH with imem_req=1. Any in-flight fetch is abandoned.
  - exc in BOOT takes effect on the BOOT->FETCH transition.
- Wrap-around: pc 32'hFFFF_FFFC + 4 = 32'h0000_0000. No error is raised.

Optional Feature:
ALIGN_CHECK_EN
- Defined: a jr with jr_target[1:0]!=0 is treated as an exception. It redirects to EXC_VECTOR immediately, as exc does, and pulses addr_err for one cycle.
- Undefined: the low bits are silently forced to 00 and addr_err is tied 0.

Test Plan:
- Reset, then imem_ready=1 and stall=0 held -> cycle 1 imem_req=0, pc=0; cycle 2 imem_req=1; pc then steps 0x0, 0x4, 0x8, one step per cycle.
- pc=0x100, br_take=1, br_offset=16'hFFFF, ready=1 -> next pc=0x100; with br_offset=16'h0010 -> 0x144.
- pc=0xA000_0010, jump=1, jump_index=26'h40 -> pc=0xA000_0100; same cycle with jr=1, jr_target=0x2000 -> pc=0x2000 (jr wins).
- pc=0x200, imem_ready=0, br_take=1, br_offset=4 for one cycle; ready=1 two cycles later -> redirect_pend=1 during the wait; pc becomes 0x214; redirect_pend then clears.
- ready=1 & stall=1 at pc=0x40 -> HOLD, imem_req=0, pc stays 0x40 for 3 stall cycles; stall=0 -> pc=0x44, imem_req=1.
- exc during FETCH with ready=0 and a branch pending -> pc=0x80 next cycle, redirect_pend=0. With ALIGN_CHECK_EN, jr_target=0x1002 -> pc=0x80 and addr_err pulse.
